// File: rtl/rd_sched_rr_if.sv
// Read-scheduler bus: request/ready inputs and the mux output stream from the
// buffers, plus the grant and mux control the scheduler returns to them.
interface rd_sched_rr_if #(
    parameter int IN_PORT_NUM = 16,
    parameter int SEL_W       = $clog2(IN_PORT_NUM)
);
    logic [IN_PORT_NUM-1:0] i_req;
    logic                   i_out_rdy;
    logic                   i_rd_vld;
    logic                   i_rd_sop;
    logic                   i_rd_eop;
    logic [IN_PORT_NUM-1:0] o_rd_grant;
    logic                   o_en;
    logic [SEL_W-1:0]       o_sel;
    logic                   o_busy;
    logic                   o_timeout;
    logic                   o_proto_err;

    // Side that owns the input buffers and the downstream stage
    modport master (
        output i_req, i_out_rdy, i_rd_vld, i_rd_sop, i_rd_eop,
        input  o_rd_grant, o_en, o_sel, o_busy, o_timeout, o_proto_err
    );

    // Scheduler side
    modport slave (
        input  i_req, i_out_rdy, i_rd_vld, i_rd_sop, i_rd_eop,
        output o_rd_grant, o_en, o_sel, o_busy, o_timeout, o_proto_err
    );
endinterface

// File: rtl/rd_sched_rr.sv
// Per-output-port round-robin read scheduler. Picks one requesting input port,
// holds the grant and mux select for the whole packet (sop..eop) by watching the
// mux output stream, and gives up if the granted port never produces a sop.
module rd_sched_rr #(
    parameter int IN_PORT_NUM = 16,
    parameter int SEL_W       = $clog2(IN_PORT_NUM),
    parameter int SOP_TIMEOUT = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    rd_sched_rr_if.slave bus
);

    localparam int                CNT_W    = $clog2(SOP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SOP_TIMEOUT - 1);
    localparam logic [SEL_W-1:0]  PTR_INIT = SEL_W'(IN_PORT_NUM - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOP,
        XFER
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IN_PORT_NUM-1:0] grant_q, grant_d;
    logic                   en_q, en_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic                   proto_err_q, proto_err_d;

    logic                   found;
    logic [SEL_W-1:0]       winner;

    // Round-robin search: first requesting port after the last granted one
    always_comb begin : rr_scan
        int scan_idx;
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int off = 1; off <= IN_PORT_NUM; off++) begin
            scan_idx = int'(ptr_q) + off;
            if (scan_idx >= IN_PORT_NUM) begin
                scan_idx = scan_idx - IN_PORT_NUM;
            end
            if (!found && bus.i_req[SEL_W'(scan_idx)]) begin
                found  = 1'b1;
                winner = SEL_W'(scan_idx);
            end
        end
    end

    // Next-state and next-output logic; error/timeout flags are single-cycle pulses
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        en_d        = en_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        proto_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
                if (bus.i_out_rdy && found) begin
                    state_d         = WAIT_SOP;
                    grant_d[winner] = 1'b1;
                    sel_d           = winner;
                    en_d            = 1'b1;
                    busy_d          = 1'b1;
                    ptr_d           = winner;
                    cnt_d           = '0;
                end
            end

            WAIT_SOP: begin
                if (bus.i_rd_vld) begin
                    if (bus.i_rd_sop) begin
                        if (bus.i_rd_eop) begin
                            state_d = IDLE;
                            grant_d = '0;
                            en_d    = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = XFER;
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    grant_d   = '0;
                    en_d      = 1'b0;
                    busy_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            XFER: begin
                if (bus.i_rd_vld) begin
                    if (bus.i_rd_sop) begin
                        proto_err_d = 1'b1;
                    end
                    if (bus.i_rd_eop) begin
                        state_d = IDLE;
                        grant_d = '0;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any packet in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            ptr_q       <= PTR_INIT;
            cnt_q       <= '0;
            grant_q     <= '0;
            en_q        <= 1'b0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            en_q        <= en_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign bus.o_rd_grant  = grant_q;
    assign bus.o_en        = en_q;
    assign bus.o_sel       = sel_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_proto_err = proto_err_q;

endmodule

// File: tb/tb_rd_sched_rr.sv
// Testbench for rd_sched_rr: directed vector table, hand-written corner-case
// sequences and a randomized packet-level run against a reference model.
module tb_rd_sched_rr;

    localparam int N   = 16;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic rst;

    int nChecks = 0;
    int nFails  = 0;
    int mPtr    = N - 1;
    int mSel    = 0;

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        logic        vld;
        logic        sop;
        logic        eop;
        logic [15:0] eGrant;
        logic        eEn;
        int          eSel;
        logic        eBusy;
        logic        eTo;
        logic        ePe;
    } vec_t;

    vec_t vecs [16];

    rd_sched_rr_if #(.IN_PORT_NUM(N)) bus ();

    rd_sched_rr #(
        .IN_PORT_NUM(N),
        .SEL_W      (4),
        .SOP_TIMEOUT(TMO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Guard against a hung run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [15:0] req, input logic rdy, input logic vld,
                                input logic sop, input logic eop, input logic [15:0] eGrant,
                                input logic eEn, input int eSel, input logic eBusy,
                                input logic eTo, input logic ePe);
        vec_t v;
        v.req = req; v.rdy = rdy; v.vld = vld; v.sop = sop; v.eop = eop;
        v.eGrant = eGrant; v.eEn = eEn; v.eSel = eSel; v.eBusy = eBusy;
        v.eTo = eTo; v.ePe = ePe;
        return v;
    endfunction

    // Reference arbitration: rotate the request vector so the port after ptr
    // lands at bit 0, take the lowest set bit, rotate the index back.
    function automatic int rrWinner(input int ptr, input logic [15:0] req);
        logic [31:0] both;
        both = {req, req} >> (ptr + 1);
        for (int k = 0; k < N; k++) begin
            if (both[k]) return (ptr + 1 + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] req, input logic rdy, input logic vld,
                                 input logic sop, input logic eop);
        bus.i_req     = req;
        bus.i_out_rdy = rdy;
        bus.i_rd_vld  = vld;
        bus.i_rd_sop  = sop;
        bus.i_rd_eop  = eop;
        tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [15:0] eGrant, input logic eEn,
                            input int eSel, input logic eBusy, input logic eTo, input logic ePe);
        checkOutput({tag, " grant"},     32'(bus.o_rd_grant), 32'(eGrant));
        checkOutput({tag, " en"},        32'(bus.o_en), 32'(eEn));
        checkOutput({tag, " sel"},       32'(bus.o_sel), 32'(eSel));
        checkOutput({tag, " busy"},      32'(bus.o_busy), 32'(eBusy));
        checkOutput({tag, " timeout"},   32'(bus.o_timeout), 32'(eTo));
        checkOutput({tag, " proto_err"}, 32'(bus.o_proto_err), 32'(ePe));
        checkOutput({tag, " onehot"},    32'($onehot0(bus.o_rd_grant)), 32'd1);
    endtask

    // Present a request in IDLE and check the model's predicted winner is granted
    task automatic expectGrant(input logic [15:0] req, input string tag, output int port);
        applyStimulus(req, 1'b1, 1'b0, 1'b0, 1'b0);
        port = rrWinner(mPtr, req);
        mPtr = port;
        mSel = port;
        checkAll(tag, 16'h1 << port, 1'b1, port, 1'b1, 1'b0, 1'b0);
    endtask

    // Drive a clean packet of nBeats beats; grant holds until the eop beat ends
    task automatic runPacket(input int nBeats, input int port, input logic [15:0] noiseReq,
                             input string tag);
        for (int b = 0; b < nBeats; b++) begin
            applyStimulus(noiseReq, 1'b1, 1'b1, b == 0, b == nBeats - 1);
            if (b == nBeats - 1)
                checkAll({tag, " eop"}, 16'h0, 1'b0, port, 1'b0, 1'b0, 1'b0);
            else
                checkAll({tag, " beat"}, 16'h1 << port, 1'b1, port, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int w;
        int cyc;

        // Reset held while requests are present: nothing may be granted
        rst = 1'b1;
        bus.i_req = 16'hFFFF; bus.i_out_rdy = 1'b1;
        bus.i_rd_vld = 1'b0; bus.i_rd_sop = 1'b0; bus.i_rd_eop = 1'b0;
        applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
        checkAll("reset", 16'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Directed vectors, starting from the reset pointer
        vecs[0]  = mk(16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        vecs[3]  = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 2, 1'b1, 1'b0, 1'b1);
        vecs[9]  = mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        vecs[10] = mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        vecs[13] = mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b1, 1, 1'b1, 1'b0, 1'b1);
        vecs[14] = mk(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, vecs[i].rdy, vecs[i].vld, vecs[i].sop, vecs[i].eop);
            checkAll($sformatf("vec%0d", i), vecs[i].eGrant, vecs[i].eEn, vecs[i].eSel,
                     vecs[i].eBusy, vecs[i].eTo, vecs[i].ePe);
        end
        mPtr = 1;
        mSel = 1;

        // Wrap-around: with ptr at 5, port 0 wins over port 5, then port 5
        expectGrant(16'h0020, "wrap pre", w);
        runPacket(1, w, 16'h0000, "wrap pre");
        expectGrant(16'h0021, "wrap a", w);
        checkOutput("wrap_first_port", 32'(bus.o_sel), 32'd0);
        runPacket(2, w, 16'h0021, "wrap a");
        expectGrant(16'h0021, "wrap b", w);
        checkOutput("wrap_second_port", 32'(bus.o_sel), 32'd5);
        runPacket(3, w, 16'h0000, "wrap b");

        // SOP timeout on port 3, then the pointer has moved past it
        expectGrant(16'h0008, "tmo grant", w);
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
            applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
            if (bus.o_timeout) begin
                cyc = c;
                break;
            end
        end
        checkOutput("timeout_latency", 32'(cyc), 32'(TMO));
        checkAll("tmo release", 16'h0, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("tmo pulse end", 16'h0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
        expectGrant(16'h0018, "after tmo", w);
        checkOutput("after_timeout_port", 32'(bus.o_sel), 32'd4);
        runPacket(1, w, 16'h0000, "after tmo");

        // Reset during beat 2 of a packet abandons it and resets the pointer
        expectGrant(16'h0080, "rst grant", w);
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        checkAll("rst beat1", 16'h0080, 1'b1, 7, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        applyStimulus(16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        checkAll("rst mid xfer", 16'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        mPtr = N - 1;
        mSel = 0;

        // All ports requesting: strict rotation 0..15,0 with 4-beat packets
        for (int i = 0; i <= N; i++) begin
            expectGrant(16'hFFFF, $sformatf("rr%0d", i), w);
            checkOutput($sformatf("rr_order%0d", i), 32'(bus.o_sel), 32'(i % N));
            runPacket(4, w, 16'hFFFF, $sformatf("rr%0d", i));
        end

        // Randomized packets checked against the transaction-level model
        for (int p = 0; p < 150; p++) begin
            logic [15:0] r;
            logic        rdy;
            logic [15:0] oh;
            r   = 16'($urandom) & 16'($urandom) & 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(r, rdy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if (rdy && r != 16'h0) begin
                w    = rrWinner(mPtr, r);
                mPtr = w;
                mSel = w;
                oh   = 16'h1 << w;
                checkAll("rnd grant", oh, 1'b1, w, 1'b1, 1'b0, 1'b0);
                if ($urandom_range(0, 9) == 0) begin
                    for (int c = 1; c <= TMO; c++) begin
                        applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
                        if (c < TMO)
                            checkAll("rnd wait", oh, 1'b1, w, 1'b1, 1'b0, 1'b0);
                        else
                            checkAll("rnd timeout", 16'h0, 1'b0, w, 1'b0, 1'b1, 1'b0);
                    end
                end else begin
                    int   pre;
                    int   len;
                    logic bad;
                    logic s;
                    pre = $urandom_range(0, 4);
                    for (int c = 0; c < pre; c++) begin
                        bad = ($urandom_range(0, 3) == 0);
                        applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), bad, 1'b0,
                                      1'($urandom_range(0, 1)));
                        checkAll("rnd pre", oh, 1'b1, w, 1'b1, 1'b0, bad);
                    end
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) begin
                        s = (b == 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
                        applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1'b1, s,
                                      b == len - 1);
                        if (b == len - 1)
                            checkAll("rnd eop", 16'h0, 1'b0, w, 1'b0, 1'b0, (b > 0) && s);
                        else
                            checkAll("rnd beat", oh, 1'b1, w, 1'b1, 1'b0, (b > 0) && s);
                    end
                end
            end else begin
                checkAll("rnd idle", 16'h0, 1'b0, mSel, 1'b0, 1'b0, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
